controller: RTL and testbench
=============================

CONTROLLER -- requirements
Module: controller

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed.
REQ-002 clk  input  1  rising-edge clock for the state register.
REQ-003 reset  input  1  asynchronous, active-high reset; forces state to FETCH immediately.
REQ-004 op  input  6  instruction opcode, bits 31:26 of the instruction register.
REQ-005 funct  input  6  R-type function field, bits 5:0 of the instruction register.
REQ-006 zero  input  1  ALU zero flag from the datapath.
REQ-007 pcEn  output  1  PC register write enable.
REQ-008 IorD, memwrite, IRwrite, regdst, memtoreg, regwrite, alusrcA  output  1 each  datapath mux selects and write enables.
REQ-009 alusrcB, pcsrc  output  2 each  ALU B-operand select and next-PC select.
REQ-010 alucontrol  output  3  ALU operation code.
REQ-011 state  output  4  current FSM state, for debug and verification.

Function
REQ-012 The block SHALL be a Moore FSM (one 4-bit state register) plus a combinational ALU decoder; all outputs except pcEn and alucontrol SHALL depend on state only.
REQ-013 State encodings SHALL be FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, RTYPEEX=6, RTYPEWB=7, BEQEX=8, ADDIEX=9, ADDIWB=10, JEX=11.
REQ-014 Opcodes SHALL be lw=100011, sw=101011, R-type=000000, beq=000100, addi=001000, j=000010.
REQ-015 Transitions SHALL be:
- FETCH->DECODE.
- DECODE->MEMADR for lw/sw, RTYPEEX for R-type, BEQEX for beq, ADDIEX for addi, JEX for j; any other op->FETCH.
- MEMADR->MEMRD for lw, MEMWR otherwise.
- MEMRD->MEMWB.
- RTYPEEX->RTYPEWB.
- ADDIEX->ADDIWB.
- MEMWB, MEMWR, RTYPEWB, BEQEX, ADDIWB, JEX->FETCH.
REQ-016 Codes 12-15 SHALL transition to FETCH on the next edge and drive all outputs 0.
REQ-017 Every output not listed for a state in REQ-018 SHALL be 0 (aluop=00).
REQ-018 Per-state outputs SHALL be:
- FETCH: IRwrite=1, pcwrite=1, alusrcB=01, aluop=00.
- DECODE: alusrcB=11, aluop=00.
- MEMADR: alusrcA=1, alusrcB=10.
- MEMRD: IorD=1.
- MEMWB: memtoreg=1, regwrite=1.
- MEMWR: IorD=1, memwrite=1.
- RTYPEEX: alusrcA=1, aluop=10.
- RTYPEWB: regdst=1, regwrite=1.
- BEQEX: alusrcA=1, aluop=01, pcsrc=01, branch=1.
- ADDIEX: alusrcA=1, alusrcB=10.
- ADDIWB: regwrite=1.
- JEX: pcsrc=10, pcwrite=1.
REQ-019 pcEn SHALL equal pcwrite OR (branch AND zero), combinationally, in the same cycle.
REQ-020 alucontrol SHALL be derived from aluop and funct:
- aluop=00 -> 010 (add); aluop=01 -> 110 (sub).
- aluop=10: funct 100000->010, 100010->110, 100100->000, 100101->001, 101010->111; any other funct->010.
- aluop=11 SHALL never be generated.
REQ-021 Instruction latency SHALL be, in cycles from FETCH: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, unsupported op 2.
REQ-022 op and funct SHALL be sampled only through the DECODE, MEMADR and RTYPEEX decisions and ALU decode; their changes in other states SHALL have no effect on the state sequence.

Reset
REQ-023 Asserting reset SHALL force state=FETCH asynchronously, including mid-instruction; outputs SHALL take FETCH values (IRwrite=1, pcEn=1, alusrcB=01, alucontrol=010) while reset is held.
REQ-024 The first rising clk after reset deasserts SHALL move FETCH->DECODE.

Verification
REQ-025 Reset during MEMRD of a lw -> state=0 without a clock edge; next edge -> state=1.
REQ-026 op=100011 -> states 0,1,2,3,4,0; regwrite=1 and memtoreg=1 only in state 4; IorD=1 in state 3.
REQ-027 op=000000 with funct=101010 -> in state 6, alucontrol=111; in state 7, regdst=1 and regwrite=1; then state 0.
REQ-028 op=000100 in BEQEX with zero=1 -> pcEn=1, pcsrc=01; same with zero=0 -> pcEn=0; both cases return to state 0.
REQ-029 op=000010 -> states 0,1,11,0 with pcsrc=10 and pcEn=1 in state 11; op=111111 -> states 0,1,0 and memwrite/regwrite never asserted.
REQ-030 op=101011 -> states 0,1,2,5,0 with memwrite=1 only in state 5.

Source files
------------

// File: rtl/controller.sv
// Multicycle controller: Moore control FSM plus combinational ALU decoder.
// Every output except pcEn and alucontrol is a function of the state alone.
module controller (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       pcEn,
  output logic       IorD,
  output logic       memwrite,
  output logic       IRwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       regwrite,
  output logic       alusrcA,
  output logic [1:0] alusrcB,
  output logic [1:0] pcsrc,
  output logic [2:0] alucontrol,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    RTYPEEX = 4'd6,
    RTYPEWB = 4'd7,
    BEQEX   = 4'd8,
    ADDIEX  = 4'd9,
    ADDIWB  = 4'd10,
    JEX     = 4'd11
  } state_t;

  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_RTYP = 6'b000000;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;

  state_t     state_q, state_d;
  logic       pcwrite, branch;
  logic [1:0] aluop;

  assign state = state_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= FETCH;
    else       state_q <= state_d;
  end

  // Unused codes 12-15 fall into the default and recover to FETCH.
  always_comb begin
    state_d = FETCH;
    case (state_q)
      FETCH:   state_d = DECODE;
      DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_RTYP:      state_d = RTYPEEX;
          OP_BEQ:       state_d = BEQEX;
          OP_ADDI:      state_d = ADDIEX;
          OP_J:         state_d = JEX;
          default:      state_d = FETCH;
        endcase
      end
      MEMADR:  state_d = (op == OP_LW) ? MEMRD : MEMWR;
      MEMRD:   state_d = MEMWB;
      RTYPEEX: state_d = RTYPEWB;
      ADDIEX:  state_d = ADDIWB;
      default: state_d = FETCH;
    endcase
  end

  always_comb begin
    IorD     = 1'b0;
    memwrite = 1'b0;
    IRwrite  = 1'b0;
    regdst   = 1'b0;
    memtoreg = 1'b0;
    regwrite = 1'b0;
    alusrcA  = 1'b0;
    alusrcB  = 2'b00;
    pcsrc    = 2'b00;
    aluop    = 2'b00;
    pcwrite  = 1'b0;
    branch   = 1'b0;
    case (state_q)
      FETCH: begin
        IRwrite = 1'b1;
        pcwrite = 1'b1;
        alusrcB = 2'b01;
      end
      DECODE:  alusrcB = 2'b11;
      MEMADR: begin
        alusrcA = 1'b1;
        alusrcB = 2'b10;
      end
      MEMRD:   IorD = 1'b1;
      MEMWB: begin
        memtoreg = 1'b1;
        regwrite = 1'b1;
      end
      MEMWR: begin
        IorD     = 1'b1;
        memwrite = 1'b1;
      end
      RTYPEEX: begin
        alusrcA = 1'b1;
        aluop   = 2'b10;
      end
      RTYPEWB: begin
        regdst   = 1'b1;
        regwrite = 1'b1;
      end
      BEQEX: begin
        alusrcA = 1'b1;
        aluop   = 2'b01;
        pcsrc   = 2'b01;
        branch  = 1'b1;
      end
      ADDIEX: begin
        alusrcA = 1'b1;
        alusrcB = 2'b10;
      end
      ADDIWB:  regwrite = 1'b1;
      JEX: begin
        pcsrc   = 2'b10;
        pcwrite = 1'b1;
      end
      default: ;
    endcase
  end

  assign pcEn = pcwrite | (branch & zero);

  // aluop=11 is never produced; it shares the add fallback.
  always_comb begin
    alucontrol = 3'b010;
    case (aluop)
      2'b01: alucontrol = 3'b110;
      2'b10: begin
        case (funct)
          6'b100000: alucontrol = 3'b010;
          6'b100010: alucontrol = 3'b110;
          6'b100100: alucontrol = 3'b000;
          6'b100101: alucontrol = 3'b001;
          6'b101010: alucontrol = 3'b111;
          default:   alucontrol = 3'b010;
        endcase
      end
      default: alucontrol = 3'b010;
    endcase
  end

endmodule

// File: tb/tb_controller.sv
// Directed bench for controller: expected state/output vectors are queued by a
// reference model when an instruction is launched and popped each cycle.
module tb_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] op, funct;
  logic       zero;
  logic       pcEn, IorD, memwrite, IRwrite, regdst, memtoreg, regwrite, alusrcA;
  logic [1:0] alusrcB, pcsrc;
  logic [2:0] alucontrol;
  logic [3:0] state;

  controller dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
    .pcEn(pcEn), .IorD(IorD), .memwrite(memwrite), .IRwrite(IRwrite),
    .regdst(regdst), .memtoreg(memtoreg), .regwrite(regwrite), .alusrcA(alusrcA),
    .alusrcB(alusrcB), .pcsrc(pcsrc), .alucontrol(alucontrol), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  st;
    logic [14:0] vec;
  } sb_t;

  sb_t q[$];
  int  errors = 0;
  int  checks = 0;

  wire [14:0] dut_vec = {pcEn, IorD, memwrite, IRwrite, regdst, memtoreg, regwrite,
                         alusrcA, alusrcB, pcsrc, alucontrol};

  function automatic logic [3:0] nxt_m(input logic [3:0] s, input logic [5:0] o);
    case (s)
      4'd0: return 4'd1;
      4'd1: begin
        if (o == 6'b100011 || o == 6'b101011) return 4'd2;
        if (o == 6'b000000) return 4'd6;
        if (o == 6'b000100) return 4'd8;
        if (o == 6'b001000) return 4'd9;
        if (o == 6'b000010) return 4'd11;
        return 4'd0;
      end
      4'd2: return (o == 6'b100011) ? 4'd3 : 4'd5;
      4'd3: return 4'd4;
      4'd6: return 4'd7;
      4'd9: return 4'd10;
      default: return 4'd0;
    endcase
  endfunction

  function automatic logic [14:0] out_m(input logic [3:0] s, input logic z, input logic [5:0] f);
    logic iord, mw, irw, rd, mtr, rw, sa, pw, br;
    logic [1:0] sb, ps, aop;
    logic [2:0] ac;
    {iord, mw, irw, rd, mtr, rw, sa, pw, br} = '0;
    sb = 2'b00; ps = 2'b00; aop = 2'b00;
    if (s == 4'd0) begin irw = 1; pw = 1; sb = 2'b01; end
    if (s == 4'd1) sb = 2'b11;
    if (s == 4'd2 || s == 4'd9) begin sa = 1; sb = 2'b10; end
    if (s == 4'd3) iord = 1;
    if (s == 4'd4) begin mtr = 1; rw = 1; end
    if (s == 4'd5) begin iord = 1; mw = 1; end
    if (s == 4'd6) begin sa = 1; aop = 2'b10; end
    if (s == 4'd7) begin rd = 1; rw = 1; end
    if (s == 4'd8) begin sa = 1; aop = 2'b01; ps = 2'b01; br = 1; end
    if (s == 4'd10) rw = 1;
    if (s == 4'd11) begin ps = 2'b10; pw = 1; end
    ac = 3'b010;
    if (aop == 2'b01) ac = 3'b110;
    if (aop == 2'b10) begin
      if (f == 6'b100010) ac = 3'b110;
      else if (f == 6'b100100) ac = 3'b000;
      else if (f == 6'b100101) ac = 3'b001;
      else if (f == 6'b101010) ac = 3'b111;
    end
    return {pw | (br & z), iord, mw, irw, rd, mtr, rw, sa, sb, ps, ac};
  endfunction

  // Queue the model's state walk from s0 until it would return to FETCH.
  task automatic gen(input logic [3:0] s0, input logic [5:0] o, input logic z, input logic [5:0] f);
    logic [3:0] s;
    int n;
    s = s0; n = 0;
    do begin
      q.push_back('{s, out_m(s, z, f)});
      s = nxt_m(s, o);
      n++;
    end while (s != 4'd0 && n < 16);
  endtask

  task automatic pop_cmp(input string tag);
    sb_t e;
    checks++;
    if (q.size() == 0) begin
      errors++;
      $error("FAIL %s scoreboard empty, state got=%0d", tag, state);
    end else begin
      e = q.pop_front();
      assert (state === e.st) else begin
        errors++;
        $error("FAIL %s state got=%0d exp=%0d", tag, state, e.st);
      end
      checks++;
      assert (dut_vec === e.vec) else begin
        errors++;
        $error("FAIL %s outputs in state %0d got=%b exp=%b", tag, e.st, dut_vec, e.vec);
      end
    end
  endtask

  task automatic chk_idle(input string tag);
    checks++;
    assert (state === 4'd0) else begin
      errors++;
      $error("FAIL %s end state got=%0d exp=0", tag, state);
    end
  endtask

  // Entered just after a rising edge with the DUT in FETCH; runs lat cycles.
  task automatic run(input logic [5:0] o, input logic [5:0] f, input logic z,
                     input int lat, input bit scr, input string tag);
    logic [3:0] cs;
    op = o; funct = f; zero = z;
    gen(4'd0, o, z, f);
    for (int i = 0; i < lat; i++) begin
      @(negedge clk);
      cs = (q.size() != 0) ? q[0].st : 4'd0;
      pop_cmp(tag);
      if (scr) op = (cs == 4'd1 || cs == 4'd2) ? o : 6'($urandom);
      @(posedge clk);
    end
    #1;
    chk_idle(tag);
    q.delete();
  endtask

  initial begin
    reset = 1'b1; op = 6'd0; funct = 6'd0; zero = 1'b0;

    @(negedge clk);
    q.push_back('{4'd0, out_m(4'd0, 1'b0, 6'd0)});
    pop_cmp("reset");
    @(posedge clk); #1;
    q.push_back('{4'd0, out_m(4'd0, 1'b0, 6'd0)});
    pop_cmp("reset_held");
    reset = 1'b0;

    run(6'b100011, 6'd0,       1'b0, 5, 1'b1, "lw");
    run(6'b101011, 6'd0,       1'b0, 4, 1'b1, "sw");
    run(6'b000000, 6'b101010,  1'b0, 4, 1'b1, "rtype_slt");
    run(6'b000000, 6'b100000,  1'b1, 4, 1'b0, "rtype_add");
    run(6'b000000, 6'b100010,  1'b0, 4, 1'b0, "rtype_sub");
    run(6'b000000, 6'b100100,  1'b0, 4, 1'b0, "rtype_and");
    run(6'b000000, 6'b100101,  1'b0, 4, 1'b0, "rtype_or");
    run(6'b000000, 6'b111111,  1'b0, 4, 1'b0, "rtype_other");
    run(6'b001000, 6'b101010,  1'b0, 4, 1'b1, "addi");
    run(6'b000100, 6'd0,       1'b1, 3, 1'b1, "beq_taken");
    run(6'b000100, 6'd0,       1'b0, 3, 1'b1, "beq_not_taken");
    run(6'b000010, 6'd0,       1'b1, 3, 1'b1, "j");
    run(6'b111111, 6'd0,       1'b0, 2, 1'b1, "bad_op");
    run(6'b000011, 6'b101010,  1'b1, 2, 1'b0, "bad_op2");

    // Asynchronous reset while a lw sits in MEMRD.
    op = 6'b100011; funct = 6'd0; zero = 1'b0;
    q.push_back('{4'd0, out_m(4'd0, 1'b0, 6'd0)});
    q.push_back('{4'd1, out_m(4'd1, 1'b0, 6'd0)});
    q.push_back('{4'd2, out_m(4'd2, 1'b0, 6'd0)});
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); pop_cmp("lw_pre_reset"); @(posedge clk);
    end
    @(negedge clk);
    q.push_back('{4'd3, out_m(4'd3, 1'b0, 6'd0)});
    pop_cmp("lw_memrd");
    #1 reset = 1'b1;
    #1;
    q.push_back('{4'd0, out_m(4'd0, 1'b0, 6'd0)});
    pop_cmp("async_reset");
    reset = 1'b0;
    gen(4'd1, 6'b100011, 1'b0, 6'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); pop_cmp("lw_after_reset"); @(posedge clk);
    end
    #1;
    chk_idle("lw_after_reset");
    q.delete();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
